// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: accepts a byte request and walks START, DATA, optional
// PARITY and STOP phases, driving serializer enable, bit index and line mux select.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Data_Valid,
  input  logic          PAR_EN,
  output logic          data_ld,
  output logic          ser_en,
  output logic [IW-1:0] bit_idx,
  output logic [1:0]    mux_sel,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0]    MUX_START  = 2'b00;
  localparam logic [1:0]    MUX_DATA   = 2'b01;
  localparam logic [1:0]    MUX_PARITY = 2'b10;
  localparam logic [1:0]    MUX_IDLE   = 2'b11;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_WIDTH - 1);
  // stop_cnt value during the final stop bit
  localparam logic          STOP_LAST  = (STOP_BITS == 2);

  state_t state;
  logic   par_en_q;
  logic   stop_cnt;

  // Gated by reset so no load strobe escapes while the sequencer is held in reset.
  assign data_ld = reset & Data_Valid & (state == IDLE);

  // Outputs are assigned alongside the next state so they are registered Moore
  // decodes of the state the machine is entering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mux_sel    <= MUX_IDLE;
      busy       <= 1'b0;
      ser_en     <= 1'b0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
      par_en_q   <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            par_en_q <= PAR_EN;
            state    <= START;
            mux_sel  <= MUX_START;
            busy     <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          mux_sel <= MUX_DATA;
          ser_en  <= 1'b1;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_idx == LAST_IDX) begin
            ser_en   <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            if (par_en_q) begin
              state   <= PARITY;
              mux_sel <= MUX_PARITY;
            end else begin
              state   <= STOP;
              mux_sel <= MUX_IDLE;
            end
          end else begin
            bit_idx <= bit_idx + IW'(1);
          end
        end
        PARITY: begin
          state    <= STOP;
          mux_sel  <= MUX_IDLE;
          stop_cnt <= 1'b0;
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mux_sel  <= MUX_IDLE;
          busy     <= 1'b0;
          ser_en   <= 1'b0;
          bit_idx  <= '0;
          stop_cnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (1 and 2 stop bits) share stimulus;
// a frame-level reference model queues expected line symbols, monitors pop and compare.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       data_ld    [2];
  logic       ser_en     [2];
  logic       busy       [2];
  logic       frame_done [2];
  logic [2:0] bit_idx    [2];
  logic [1:0] mux_sel    [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit finishing = 1'b0;

  typedef struct packed {
    logic [1:0] mux;
    logic [2:0] idx;
    logic       ser;
    logic       last;
  } sym_t;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned SB = g + 1;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(SB)) dut (
      .clk        (clk),
      .reset      (reset),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .data_ld    (data_ld[g]),
      .ser_en     (ser_en[g]),
      .bit_idx    (bit_idx[g]),
      .mux_sel    (mux_sel[g]),
      .busy       (busy[g]),
      .frame_done (frame_done[g])
    );

    sym_t q[$];
    int   free_at = 0;
    bit   pend_done = 1'b0;

    // Reference model: a request is taken when the line is free; the frame then
    // occupies 1+8+parity+SB cycles and the next request is possible one cycle later.
    always @(negedge clk) begin : model
      bit acc;
      if (!reset) begin
        free_at = 0;
        chk($sformatf("reset_vals%0d", g),
            {mux_sel[g], busy[g], ser_en[g], bit_idx[g], frame_done[g], data_ld[g]},
            9'b11_0_0_000_0_0);
      end else begin
        acc = Data_Valid && (cyc >= free_at);
        chk($sformatf("data_ld%0d", g), data_ld[g], acc);
        if (acc) begin
          q.push_back('{2'b00, 3'd0, 1'b0, 1'b0});
          for (int i = 0; i < 8; i++) q.push_back('{2'b01, 3'(i), 1'b1, 1'b0});
          if (PAR_EN) q.push_back('{2'b10, 3'd0, 1'b0, 1'b0});
          for (int s = 0; s < int'(SB); s++)
            q.push_back('{2'b11, 3'd0, 1'b0, s == int'(SB) - 1});
          free_at = cyc + 10 + int'(PAR_EN) + int'(SB);
        end
      end
    end

    always @(posedge clk) begin : mon
      sym_t s;
      #1;
      if (!reset) begin
        q.delete();
        pend_done = 1'b0;
      end else begin
        chk($sformatf("frame_done%0d", g), frame_done[g], pend_done);
        if (pend_done) chk($sformatf("gap_idle%0d", g), busy[g], 1'b0);
        pend_done = 1'b0;
        chk($sformatf("busy%0d", g), busy[g], q.size() != 0);
        if (busy[g] && q.size() != 0) begin
          s = q.pop_front();
          chk($sformatf("symbol%0d", g), {mux_sel[g], bit_idx[g], ser_en[g]},
              {s.mux, s.idx, s.ser});
          pend_done = s.last;
        end else if (!busy[g]) begin
          chk($sformatf("idle_out%0d", g), {mux_sel[g], bit_idx[g], ser_en[g]},
              {2'b11, 3'd0, 1'b0});
        end
      end
      if (finishing) chk($sformatf("queue_drained%0d", g), q.size(), 0);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(bit par);
    Data_Valid = 1'b1;
    PAR_EN     = par;
    tick(1);
    Data_Valid = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b1;
    tick(2);

    // single frames with and without parity
    pulse(1'b1); tick(16);
    pulse(1'b0); tick(16);

    // requests during a frame are ignored; PAR_EN flip mid-frame has no effect
    pulse(1'b1);
    PAR_EN = 1'b0;
    tick(2);
    Data_Valid = 1'b1; tick(1); Data_Valid = 1'b0;
    tick(5);
    Data_Valid = 1'b1; tick(1); Data_Valid = 1'b0;
    tick(16);

    // asynchronous reset while the 1-stop instance shows bit_idx=4
    pulse(1'b1);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("async_reset%0d", i), {mux_sel[i], busy[i], ser_en[i]}, 4'b1100);
    tick(2);
    reset = 1'b1;
    tick(1);
    pulse(1'b1); tick(16);

    // back-to-back frames with Data_Valid held
    Data_Valid = 1'b1;
    PAR_EN     = 1'b1;
    tick(36);
    Data_Valid = 1'b0;
    tick(16);

    // random traffic with occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      PAR_EN     = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 199) != 0);
      tick(1);
    end

    reset      = 1'b1;
    Data_Valid = 1'b0;
    tick(20);
    finishing = 1'b1;
    tick(1);
    finishing = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
